hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the five-stage pipeline hazard unit. It adds a one-entry scoreboard for a multi-cycle multiply/divide (MD) unit and a saturating stall-cycle counter. It keeps the existing capabilities: E-stage forwarding from M/W, D-stage branch forwarding, load-use stall and branch stall. It sits beside the datapath and drives the forwarding muxes plus the F/D/E stall and flush controls.

Parameters:
REG_W, 5, register-address width (register file has 2^REG_W entries, register 0 hard-wired to zero)
MD_LAT, 4, MD unit latency in cycles from MdStartE to result write (legal range 2..15)
STAT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsD, RtD  in  REG_W  D-stage source registers
RsE, RtE  in  REG_W  E-stage source registers
WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
MemtoRegE, MemtoRegM  in  1  load in E / M
BranchD  in  1  branch in D
MdOpD  in  1  D-stage instruction is an MD op
MdStartE  in  1  MD op in E; launches the MD unit this cycle
MdDestE  in  REG_W  GPR destination of the launching MD op
StatClr  in  1  synchronous clear of StallCount
ForwardAE, ForwardBE  out  2  E operand select: 10=M, 01=W, 00=register file
ForwardAD, ForwardBD  out  1  D branch-comparator forward from M
StallF, StallD, FlushE  out  1  pipeline controls
MdBusy  out  1  MD unit in flight
MdDone  out  1  one-cycle pulse; MD result written to GPR this cycle
StallCount  out  STAT_W  saturating count of cycles with StallD=1

Behaviour:
- Forwarding (combinational):
  - ForwardAE=10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if the same test matches W; else 00. M has priority over W.
  - ForwardBE follows the same rule on RtE.
  - ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM; ForwardBD uses RtD.
- lwstall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- MD scoreboard (sequential):
  - State: cnt (4 bits) and pend_reg (REG_W). MdBusy = (cnt!=0).
  - Launch: MdStartE && !MdBusy loads cnt=MD_LAT-1 and pend_reg=MdDestE.
  - MdStartE while MdBusy is ignored; state is unchanged.
  - While cnt!=0, cnt decrements each cycle. MdDone = (cnt==1), registered-state decode.
  - pend_valid = MdBusy && pend_reg!=0.
- mdstall = (MdOpD && MdBusy) || (pend_valid && (RsD==pend_reg || RtD==pend_reg)).
  - The stall holds through the MdDone cycle and releases the cycle after, when cnt==0.
- StallF = StallD = FlushE = lwstall || branchstall || mdstall.
- StallCount:
  - Increments each cycle StallD=1.
  - Saturates at 2^STAT_W-1; no wrap.
  - StatClr has priority over increment (value becomes 0 next cycle).
- Reset: on rst_n low, immediately cnt=0, pend_reg=0, StallCount=0. Hence MdBusy=0 and MdDone=0.
  - Combinational outputs follow inputs during reset.
  - Reset mid-MD-operation abandons the op; no MdDone pulse is produced.
- Simultaneous events:
  - MdStartE in the same cycle FlushE=1 still launches, because the MD op is a valid E instruction; the flush affects the next E contents.
  - Launch on the cycle after cnt returns to 0 is legal; there is no dead cycle.

Test Plan:
- Forward priority: RsE=RtE=3, WriteRegM=WriteRegW=3, RegWriteM=RegWriteW=1 -> ForwardAE=ForwardBE=10. With RegWriteM=0 -> 01. With RsE=RtE=0 -> 00.
- Load-use: MemtoRegE=1, RtE=7, RsD=7 -> StallF=StallD=FlushE=1 for that cycle only. Same with RtE=0 -> no stall.
- Branch: BranchD=1, RsD=4, RegWriteE=1, WriteRegE=4 -> stall. Next cycle (E moved to M, MemtoRegM=1, WriteRegM=4) -> stall. Then MemtoRegM=0 -> no stall, ForwardAD=1.
- MD with MD_LAT=4: MdStartE=1, MdDestE=9 at cycle 0.
  - MdBusy=1 for cycles 1-3; MdDone=1 in cycle 3 only.
  - RsD=9 stalls cycles 1-3 and releases in cycle 4.
  - MdOpD=1 in cycle 2 stalls; a second MdStartE in cycle 2 is ignored.
- Reset mid-op: deassert rst_n in cycle 2 of an MD op -> MdBusy=0 immediately. After release, no MdDone and no mdstall.
- StallCount with STAT_W=3: hold a load-use stall for 10 cycles -> count reads 7 and holds. StatClr=1 with the stall still active -> 0 next cycle, then resumes counting.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit with MD scoreboard: E/D forwarding, load-use/branch/MD stalls, stall counter.
// Latency: forwarding and stall controls combinational; MD busy/done from registered state.
// Backpressure: any hazard asserts StallF/StallD/FlushE together; no input is ever refused.
module hazard_scoreboard #(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RsE,
    input  logic [REG_W-1:0]  RtE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [REG_W-1:0]  WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    input  logic              BranchD,
    input  logic              MdOpD,
    input  logic              MdStartE,
    input  logic [REG_W-1:0]  MdDestE,
    input  logic              StatClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdDone,
    output logic [STAT_W-1:0] StallCount
);

    // Countdown start value: the result lands MD_LAT-1 cycles after the launch edge.
    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [3:0]        cnt_q, cnt_d;
    logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
    logic [STAT_W-1:0] stall_count_q, stall_count_d;

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic pend_valid;
    logic stall;

    // E-stage operand forwarding; the younger M result wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != '0 && RsE == WriteRegM && RegWriteM)      ForwardAE = 2'b10;
        else if (RsE != '0 && RsE == WriteRegW && RegWriteW) ForwardAE = 2'b01;
        if (RtE != '0 && RtE == WriteRegM && RegWriteM)      ForwardBE = 2'b10;
        else if (RtE != '0 && RtE == WriteRegW && RegWriteW) ForwardBE = 2'b01;
        ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
    end

    // Hazard detection; a register-0 destination never creates a dependency.
    always_comb begin
        MdBusy      = (cnt_q != 4'd0);
        MdDone      = (cnt_q == 4'd1);
        pend_valid  = MdBusy && (pend_reg_q != '0);
        lwstall     = MemtoRegE && (RtE != '0) && (RsD == RtE || RtD == RtE);
        branchstall = BranchD &&
                      ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
        // Held through the MdDone cycle; the GPR write is not visible to D until cnt is 0.
        mdstall     = (MdOpD && MdBusy) ||
                      (pend_valid && (RsD == pend_reg_q || RtD == pend_reg_q));
        stall       = lwstall || branchstall || mdstall;
        StallF      = stall;
        StallD      = stall;
        FlushE      = stall;
        StallCount  = stall_count_q;
    end

    // MD scoreboard next state: launch only when idle, otherwise count down.
    // A launch coinciding with FlushE still proceeds; the MD op is already in E.
    always_comb begin
        cnt_d      = cnt_q;
        pend_reg_d = pend_reg_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (MdStartE) begin
            cnt_d      = MD_LOAD;
            pend_reg_d = MdDestE;
        end
    end

    // Stall-cycle counter next state: clear beats increment, saturate at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (StatClr)                                stall_count_d = '0;
        else if (stall && stall_count_q != STAT_MAX) stall_count_d = stall_count_q + 1'b1;
    end

    // State registers; reset abandons any in-flight MD op without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= 4'd0;
            pend_reg_q    <= '0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            pend_reg_q    <= pend_reg_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MD_LAT=4, STAT_W=3).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Each task checks its own expected values inline.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MdDestE;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, MdOpD, MdStartE, StatClr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdDone;
    logic [2:0] StallCount;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(5), .MD_LAT(4), .STAT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MdOpD(MdOpD), .MdStartE(MdStartE), .MdDestE(MdDestE), .StatClr(StatClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdDone(MdDone), .StallCount(StallCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0; MdDestE = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MdOpD = 0; MdStartE = 0; StatClr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        RsE = 3; WriteRegM = 3; RegWriteM = 1;
        #3;
        nvec++; if (MdBusy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", MdBusy); end
        nvec++; if (MdDone !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", MdDone); end
        nvec++; if (StallCount !== 3'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", StallCount); end
        nvec++; if (ForwardAE !== 2'b10) begin nerr++; $display("FAIL reset_fwd_comb got %b want 10", ForwardAE); end
        step();
        rst_n = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_forward();
        idle_inputs();
        RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
        #1;
        nvec++; if (ForwardAE !== 2'b10) begin nerr++; $display("FAIL fwd_ae_m got %b want 10", ForwardAE); end
        nvec++; if (ForwardBE !== 2'b10) begin nerr++; $display("FAIL fwd_be_m got %b want 10", ForwardBE); end
        RegWriteM = 0; #1;
        nvec++; if (ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwd_ae_w got %b want 01", ForwardAE); end
        nvec++; if (ForwardBE !== 2'b01) begin nerr++; $display("FAIL fwd_be_w got %b want 01", ForwardBE); end
        RegWriteM = 1; RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0; #1;
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwd_ae_r0 got %b want 00", ForwardAE); end
        nvec++; if (ForwardBE !== 2'b00) begin nerr++; $display("FAIL fwd_be_r0 got %b want 00", ForwardBE); end
        RsE = 6; RtE = 2; WriteRegM = 2; WriteRegW = 6; #1;
        nvec++; if ({ForwardAE, ForwardBE} !== 4'b0110) begin nerr++; $display("FAIL fwd_split got %b want 0110", {ForwardAE, ForwardBE}); end
        RsD = 2; RtD = 6; #1;
        nvec++; if ({ForwardAD, ForwardBD} !== 2'b10) begin nerr++; $display("FAIL fwd_d got %b want 10", {ForwardAD, ForwardBD}); end
        step();
    endtask

    task automatic test_load_use();
        idle_inputs();
        MemtoRegE = 1; RtE = 7; RsD = 7; #1;
        nvec++; if ({StallF, StallD, FlushE} !== 3'b111) begin nerr++; $display("FAIL lw_stall got %b want 111", {StallF, StallD, FlushE}); end
        step();
        MemtoRegE = 0; RtE = 0; RsD = 7; #1;
        nvec++; if ({StallF, StallD, FlushE} !== 3'b000) begin nerr++; $display("FAIL lw_release got %b want 000", {StallF, StallD, FlushE}); end
        MemtoRegE = 1; RtE = 0; RsD = 0; #1;
        nvec++; if (StallD !== 1'b0) begin nerr++; $display("FAIL lw_r0 got %b want 0", StallD); end
        step();
    endtask

    task automatic test_branch();
        idle_inputs();
        BranchD = 1; RsD = 4; RegWriteE = 1; WriteRegE = 4; #1;
        nvec++; if (StallD !== 1'b1) begin nerr++; $display("FAIL br_e got %b want 1", StallD); end
        step();
        RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4; #1;
        nvec++; if (StallD !== 1'b1) begin nerr++; $display("FAIL br_m_load got %b want 1", StallD); end
        step();
        MemtoRegM = 0; #1;
        nvec++; if (StallD !== 1'b0) begin nerr++; $display("FAIL br_release got %b want 0", StallD); end
        nvec++; if (ForwardAD !== 1'b1) begin nerr++; $display("FAIL br_fwd_ad got %b want 1", ForwardAD); end
        step();
    endtask

    task automatic test_md();
        idle_inputs();
        MdStartE = 1; MdDestE = 9; #1;                       // cycle 0
        nvec++; if (MdBusy !== 1'b0) begin nerr++; $display("FAIL md_c0_busy got %b want 0", MdBusy); end
        step();                                               // cycle 1
        MdStartE = 0; MdDestE = 0; RsD = 9; #1;
        nvec++; if ({MdBusy, MdDone, StallD} !== 3'b101) begin nerr++; $display("FAIL md_c1 got %b want 101", {MdBusy, MdDone, StallD}); end
        step();                                               // cycle 2
        RsD = 0; MdOpD = 1; MdStartE = 1; MdDestE = 5; #1;
        nvec++; if ({MdBusy, MdDone, StallD} !== 3'b101) begin nerr++; $display("FAIL md_c2_mdop got %b want 101", {MdBusy, MdDone, StallD}); end
        step();                                               // cycle 3
        MdOpD = 0; MdStartE = 0; MdDestE = 0; RsD = 9; #1;
        nvec++; if ({MdBusy, MdDone, StallD} !== 3'b111) begin nerr++; $display("FAIL md_c3_done got %b want 111", {MdBusy, MdDone, StallD}); end
        step();                                               // cycle 4
        nvec++; if ({MdBusy, MdDone, StallD} !== 3'b000) begin nerr++; $display("FAIL md_c4_release got %b want 000", {MdBusy, MdDone, StallD}); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_op();
        logic seen_done;
        idle_inputs();
        MdStartE = 1; MdDestE = 9;
        step();
        MdStartE = 0; MdDestE = 0;
        step();                                               // cycle 2 of the op
        rst_n = 1'b0; #1;
        nvec++; if ({MdBusy, MdDone} !== 2'b00) begin nerr++; $display("FAIL rst_mid_busy got %b want 00", {MdBusy, MdDone}); end
        step();
        rst_n = 1'b1; RsD = 9;
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (MdDone !== 1'b0 || StallD !== 1'b0 || MdBusy !== 1'b0) seen_done = 1'b1;
            step();
        end
        nvec++; if (seen_done !== 1'b0) begin nerr++; $display("FAIL rst_mid_after got activity=%b want 0", seen_done); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        // Launch coinciding with a load-use flush still launches.
        MdStartE = 1; MdDestE = 12; MemtoRegE = 1; RtE = 3; RsD = 3; #1;
        nvec++; if (FlushE !== 1'b1) begin nerr++; $display("FAIL b2b_flush got %b want 1", FlushE); end
        step();                                               // cnt 3
        MemtoRegE = 0; RtE = 0; RsD = 0; MdStartE = 0;
        step();                                               // cnt 2
        step();                                               // cnt 1
        MdStartE = 1; MdDestE = 13; #1;                       // ignored: still busy
        nvec++; if (MdDone !== 1'b1) begin nerr++; $display("FAIL b2b_first_done got %b want 1", MdDone); end
        step();                                               // cnt 0, launch now legal
        nvec++; if (MdBusy !== 1'b0) begin nerr++; $display("FAIL b2b_gap got %b want 0", MdBusy); end
        step();                                               // relaunched: cnt 3
        MdStartE = 0; MdDestE = 0; RtD = 13; #1;
        nvec++; if ({MdBusy, MdDone, StallD} !== 3'b101) begin nerr++; $display("FAIL b2b_relaunch got %b want 101", {MdBusy, MdDone, StallD}); end
        step(); step();                                       // cnt 1
        nvec++; if (MdDone !== 1'b1) begin nerr++; $display("FAIL b2b_second_done got %b want 1", MdDone); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_stall_count();
        idle_inputs();
        StatClr = 1;
        step();
        StatClr = 0; #1;
        nvec++; if (StallCount !== 3'd0) begin nerr++; $display("FAIL cnt_clear got %0d want 0", StallCount); end
        MemtoRegE = 1; RtE = 7; RsD = 7;
        for (int i = 1; i <= 10; i++) begin
            step();
            nvec++;
            if (StallCount !== ((i > 7) ? 3'd7 : 3'(i))) begin
                nerr++; $display("FAIL cnt_sat_%0d got %0d want %0d", i, StallCount, (i > 7) ? 7 : i);
            end
        end
        StatClr = 1;
        step();
        nvec++; if (StallCount !== 3'd0) begin nerr++; $display("FAIL cnt_clr_prio got %0d want 0", StallCount); end
        StatClr = 0;
        step();
        nvec++; if (StallCount !== 3'd1) begin nerr++; $display("FAIL cnt_resume got %0d want 1", StallCount); end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_md();
        test_reset_mid_op();
        test_back_to_back();
        test_stall_count();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
